// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state type and the iteration counter width.
package muldiv_pkg;

    localparam int MD_N  = 32;
    localparam int CNT_W = $clog2(MD_N);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_unit_adder.sv
// Plain N-bit ripple adder with carry in/out; the one arithmetic resource
// shared by the multiply and divide datapaths.
module adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle
// through a single shared adder, fixed latency of N+2 edges to done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = MD_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    state_e             state_q;
    logic [2:0]         op_q;
    logic [N-1:0]       b_q;        // multiplicand or divisor magnitude
    logic [N-1:0]       hi_q;       // product high half / remainder
    logic [N-1:0]       lo_q;       // multiplier / quotient
    logic [CNT_W-1:0]   count_q;
    logic               sign1_q;
    logic               sign2_q;
    logic               busy_q;
    logic               done_q;
    logic [N-1:0]       result_q;

    logic [N-1:0]       add_a, add_b, add_sum;
    logic               add_cin, add_cout;
    logic [N-1:0]       hi_d, lo_d;
    logic               sgn1_acc, sgn2_acc;
    logic [N-1:0]       mag1_acc, mag2_acc;
    logic [2*N-1:0]     prod_fix;
    logic [N-1:0]       quo_fix, rem_fix, result_d;

    adder #(.N(N)) u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        if (op_q[2]) begin
            add_a   = {hi_q[N-2:0], lo_q[N-1]};
            add_b   = ~b_q;
            add_cin = 1'b1;
        end else begin
            add_a   = hi_q;
            add_b   = b_q;
            add_cin = 1'b0;
        end
    end

    // A bit shifted out of the remainder means the partial value is >= 2^N,
    // so the trial subtraction succeeds even though the N-bit adder has no carry.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_q[2]) begin
            if (add_cout || hi_q[N-1]) begin
                hi_d = add_sum;
                lo_d = {lo_q[N-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[N-2:0], lo_q[N-1]};
                lo_d = {lo_q[N-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_d, lo_d} = {add_cout, add_sum, lo_q[N-1:1]};
        end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[N-1:1]};
        end
    end

    always_comb begin
        sgn1_acc = rs1[N-1] && !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
        sgn2_acc = rs2[N-1] && !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU
                                 || op == OP_MULHSU);
        mag1_acc = sgn1_acc ? -rs1 : rs1;
        mag2_acc = sgn2_acc ? -rs2 : rs2;
    end

    // Signed overflow (-2^(N-1) / -1) falls out naturally: the magnitude
    // quotient 2^(N-1) negates to itself and the remainder is zero.
    always_comb begin
        prod_fix = (sign1_q ^ sign2_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix  = (b_q == '0) ? '1 : ((sign1_q ^ sign2_q) ? -lo_q : lo_q);
        rem_fix  = sign1_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                     result_d = prod_fix[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*N-1:N];
            OP_DIV, OP_DIVU:            result_d = quo_fix;
            default:                    result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        op_q    <= op;
                        sign1_q <= sgn1_acc;
                        sign2_q <= sgn2_acc;
                        b_q     <= op[2] ? mag2_acc : mag1_acc;
                        lo_q    <= op[2] ? mag1_acc : mag2_acc;
                        hi_q    <= '0;
                        count_q <= '0;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_W'(N - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: the driver pushes expected results into a
// queue, a forked monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;

    localparam int N   = 32;
    localparam int LAT = N + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op_s = '0;
    logic [N-1:0] rs1_s = '0;
    logic [N-1:0] rs2_s = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [N-1:0] result;

    muldiv_unit #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op_s),
        .rs1    (rs1_s),
        .rs2    (rs2_s),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] exp;
        int           acc;
        logic [2:0]   op;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;
    logic [N-1:0] last_exp = '0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold, output int acc);
        @(negedge clk);
        op_s  = o;
        rs1_s = a;
        rs2_s = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) start = 1'b0;
        check("busy_after_accept", N'(busy), N'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_within_bound", N'(busy), N'(0));
    endtask

    task automatic run_op(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] e);
        int   acc;
        exp_t item;
        issue(o, a, b, 1'b0, acc);
        item.exp = e;
        item.acc = acc;
        item.op  = o;
        sb.push_back(item);
        last_exp = e;
        wait_idle();
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] e;
    } vec_t;

    vec_t vecs[] = '{
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},  // MULHU
        '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},  // MUL
        '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},  // MULH
        '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},  // MULHSU
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB},  // MUL 7*-3
        '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF},  // MULH 7*-3
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},  // DIV -7/2
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},  // REM -7%2
        '{3'd5, 32'd100,      32'd7,        32'd14},        // DIVU
        '{3'd7, 32'd100,      32'd7,        32'd2},         // REMU
        '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF},  // DIVU /0
        '{3'd6, 32'd5,        32'd0,        32'd5},         // REM /0
        '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF},  // DIV -7/0
        '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9},  // REM -7/0
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},  // DIV overflow
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},  // REM overflow
        '{3'd5, 32'hFFFFFFFF, 32'h80000000, 32'h00000001},  // DIVU big divisor
        '{3'd7, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF},  // REMU big divisor
        '{3'd5, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000},  // DIVU a<b
        '{3'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE}   // REMU a<b
    };

    initial begin
        int acc;
        int dc0;
        exp_t item;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got result 0x%08h with nothing outstanding", result);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("result op%0d", e.op), result, e.exp);
                        check("done_edge", N'(cyc - e.acc + 1), N'(LAT));
                    end
                end
            end
        join_none

        #1 rst_n = 1'b0;
        #11;
        check("reset_busy", N'(busy), N'(0));
        check("reset_done", N'(done), N'(0));
        check("reset_result", result, N'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].e);

        // flush during CALC: no done, result unchanged
        issue(3'd5, 32'd100, 32'd7, 1'b0, acc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("busy_after_flush", N'(busy), N'(0));
        repeat (40) @(posedge clk);
        #1;
        check("result_after_flush", result, last_exp);

        run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);

        // start held high through busy and the done cycle
        dc0 = done_cnt;
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, acc);
        item.exp = 32'hFFFFFFFE;
        item.acc = acc;
        item.op  = 3'd3;
        sb.push_back(item);
        last_exp = item.exp;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("held_start_done_count", N'(done_cnt - dc0), N'(1));
        check("held_start_idle", N'(busy), N'(0));

        // asynchronous reset mid-CALC
        issue(3'd0, 32'd3, 32'd5, 1'b0, acc);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_busy", N'(busy), N'(0));
        check("async_rst_done", N'(done), N'(0));
        check("async_rst_result", result, N'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd5, 32'd100, 32'd7, 32'd14);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", N'(sb.size()), N'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
